// File: rtl/clk_div_cfg_if.sv
// Purpose : configuration/enable bundle between a ratio requester and clk_div_cfg.
// Ports   : i_enable, i_cfg_valid, i_cfg_ratio[7:0] (and i_cfg_lock when CLK_DIV_CFG_LOCK_EN)
//           into the sequencer; o_cfg_ready, o_cfg_err, o_clk_en, o_div_ratio[7:0], o_busy out.
// Modports: slave = sequencer side, master = requester/driver side.
interface clk_div_cfg_if;
    logic       i_enable;
    logic       i_cfg_valid;
    logic [7:0] i_cfg_ratio;
`ifdef CLK_DIV_CFG_LOCK_EN
    logic       i_cfg_lock;
`endif
    logic       o_cfg_ready;
    logic       o_cfg_err;
    logic       o_clk_en;
    logic [7:0] o_div_ratio;
    logic       o_busy;

`ifdef CLK_DIV_CFG_LOCK_EN
    modport slave (
        input  i_enable, i_cfg_valid, i_cfg_ratio, i_cfg_lock,
        output o_cfg_ready, o_cfg_err, o_clk_en, o_div_ratio, o_busy
    );
    modport master (
        output i_enable, i_cfg_valid, i_cfg_ratio, i_cfg_lock,
        input  o_cfg_ready, o_cfg_err, o_clk_en, o_div_ratio, o_busy
    );
`else
    modport slave (
        input  i_enable, i_cfg_valid, i_cfg_ratio,
        output o_cfg_ready, o_cfg_err, o_clk_en, o_div_ratio, o_busy
    );
    modport master (
        output i_enable, i_cfg_valid, i_cfg_ratio,
        input  o_cfg_ready, o_cfg_err, o_clk_en, o_div_ratio, o_busy
    );
`endif
endinterface

// File: rtl/clk_div_cfg.sv
// Purpose : ratio/enable sequencer for a clock divider; changes ratio or gates off only at period boundaries.
// Latency : accept->apply 1 cycle when idle, up to o_div_ratio+1 cycles running; disable->o_clk_en=0 up to o_div_ratio cycles.
// Backpr. : o_cfg_ready low while a ratio change is pending; requests then are ignored (no error).
//
// Ports: i_ref_clk (all logic on rising edge), i_rst_n (synchronous, active low),
//        cfg (clk_div_cfg_if.slave): enable level, valid/ready ratio request, error pulse,
//        divider controls o_clk_en / o_div_ratio, and o_busy while a change is pending.
// Optional: define CLK_DIV_CFG_LOCK_EN to add cfg.i_cfg_lock, which rejects every valid request.
module clk_div_cfg #(
    parameter logic [7:0] DEFAULT_RATIO = 8'd2,
    parameter logic [7:0] MIN_RATIO     = 8'd2
) (
    input  logic          i_ref_clk,
    input  logic          i_rst_n,
    clk_div_cfg_if.slave  cfg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] ratio_q, ratio_d;
    logic [7:0] pend_q,  pend_d;
    logic       err_q,   err_d;

    logic       ready;
    logic       xfer;
    logic       too_small;
    logic       locked;
    logic       legal;
    logic       boundary;

    // Ready is a pure function of the registered state, so it is glitch-free and
    // already settled at the start of each cycle.
    assign ready     = (state_q != PEND);
    assign xfer      = cfg.i_cfg_valid && ready;
    assign too_small = (cfg.i_cfg_ratio < MIN_RATIO);

`ifdef CLK_DIV_CFG_LOCK_EN
    assign locked    = cfg.i_cfg_lock;
`else
    assign locked    = 1'b0;
`endif

    assign legal     = xfer && !too_small && !locked;

    // Last reference cycle of the current divided period. The counter only runs
    // while the divider is enabled, which is exactly when state is not IDLE.
    assign boundary  = (state_q != IDLE) && (cnt_q == (ratio_q - 8'd1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        pend_d  = pend_q;
        err_d   = 1'b0;

        // A locked block rejects anything offered, even when not ready; otherwise
        // only an accepted transfer with an out-of-range ratio is rejected.
        if ((cfg.i_cfg_valid && locked) || (xfer && too_small)) begin
            err_d = 1'b1;
        end

        // Period counter: held at 0 while gated, wraps at the boundary.
        if (state_q == IDLE || boundary) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                // Divider is gated, so a new ratio can go straight out.
                if (legal) begin
                    ratio_d = cfg.i_cfg_ratio;
                end
                if (cfg.i_enable) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!cfg.i_enable && boundary) begin
                    // Gating off at the boundary; a request accepted in this same
                    // cycle can be applied immediately since the period just ended.
                    state_d = IDLE;
                    if (legal) begin
                        ratio_d = cfg.i_cfg_ratio;
                    end
                end else if (legal) begin
                    // Hold the request until the end of the current period, even if
                    // it equals the running ratio, so the counter restarts cleanly.
                    pend_d  = cfg.i_cfg_ratio;
                    state_d = PEND;
                end
            end

            PEND: begin
                if (boundary) begin
                    ratio_d = pend_q;
                    cnt_d   = 8'd0;
                    state_d = cfg.i_enable ? RUN : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            ratio_q <= DEFAULT_RATIO;
            pend_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign cfg.o_cfg_ready = ready;
    assign cfg.o_cfg_err   = err_q;
    assign cfg.o_clk_en    = (state_q != IDLE);
    assign cfg.o_div_ratio = ratio_q;
    assign cfg.o_busy      = (state_q == PEND);

endmodule

// File: doc/clk_div_cfg.md
Name: clk_div_cfg

Overview:
- Configuration and enable sequencer that sits directly upstream of the clock divider and drives its `i_clk_en` and `i_div_ratio` inputs.
- Accepts new divide ratios over a valid/ready handshake and rejects illegal values.
- Applies an accepted ratio, and gates the divider off, only at a divided-period boundary, so the divider never produces a truncated or glitched output period.
- Runs entirely in the reference-clock domain.

Parameters:
- DEFAULT_RATIO, 8'd2, ratio loaded on reset.
- MIN_RATIO, 8'd2, smallest legal requested ratio; requests below this are rejected.

Ports:
- i_ref_clk, input, 1, reference clock; all logic on its rising edge.
- i_rst_n, input, 1, synchronous active-low reset.
- i_enable, input, 1, level request to run the divider.
- i_cfg_valid, input, 1, new ratio request valid.
- i_cfg_ratio, input, 8, requested divide ratio.
- o_cfg_ready, output, 1, block can accept a request this cycle.
- o_cfg_err, output, 1, one-cycle pulse: request rejected.
- o_clk_en, output, 1, drives the divider's `i_clk_en`.
- o_div_ratio, output, 8, drives the divider's `i_div_ratio`; registered.
- o_busy, output, 1, high while a ratio change is pending.

Behaviour:
- Reset: sampled on the rising edge with i_rst_n=0. Reset wins over every other input in the same cycle.
  - Outputs after reset: o_div_ratio=DEFAULT_RATIO, o_clk_en=0, o_cfg_ready=1, o_cfg_err=0, o_busy=0.
  - Internal state after reset: state=IDLE, period counter=0, pending register=0.
- Period counter: 8-bit, tracks the divider's output period.
  - Increments every cycle o_clk_en=1; holds at 0 while o_clk_en=0.
  - Boundary = (cnt == o_div_ratio-1). On a boundary the counter wraps to 0.
  - An applied ratio change also forces the counter to 0.
- Handshake:
  - A transfer occurs when i_cfg_valid && o_cfg_ready.
  - i_cfg_ratio < MIN_RATIO: o_cfg_err=1 on the next cycle for exactly 1 cycle. No state, ratio or ready change.
  - Requests while o_cfg_ready=0 are ignored; no error is raised.
- State IDLE (o_clk_en=0):
  - Legal transfer: o_div_ratio updates on the next cycle.
  - i_enable=1: go to RUN; o_clk_en=1 on the next cycle, counter starts at 0.
  - Transfer and enable in the same cycle: the new ratio and o_clk_en=1 appear together on the next cycle.
- State RUN:
  - Legal transfer: latch into the pending register; o_cfg_ready=0 and o_busy=1 on the next cycle; go to PEND.
  - i_enable=0: o_clk_en stays 1 until the boundary cycle, then drops to 0 on the following cycle; go to IDLE.
- State PEND:
  - On a boundary: o_div_ratio <= pending value, counter <= 0, o_busy=0, o_cfg_ready=1 on the next cycle; go to RUN.
  - i_enable=0 while in PEND: the ratio is applied and o_clk_en=0 in the same update, at that boundary; go to IDLE.
- Requesting a ratio equal to the current one is still a full transfer: it is applied at the next boundary and restarts the counter.
- o_div_ratio never changes while o_clk_en=1, except in the cycle immediately after a boundary.
- Latency summary:
  - Accept to apply: 1 cycle in IDLE; up to o_div_ratio+1 cycles in RUN.
  - Disable to o_clk_en=0: up to o_div_ratio cycles.

Optional Feature:
- Macro: CLK_DIV_CFG_LOCK_EN.
- Defined:
  - Adds input port i_cfg_lock (1 bit).
  - While i_cfg_lock=1, every valid request, legal or not, is rejected with the o_cfg_err pulse and leaves all state unchanged.
  - A ratio already pending still applies at its boundary.
- Undefined: the port does not exist; behaviour is exactly as specified above.

Test Plan:
- Reset, then idle → o_div_ratio=2, o_clk_en=0, o_cfg_ready=1, o_busy=0.
- In IDLE, send ratio 8, then raise i_enable → o_div_ratio=8 one cycle after the transfer; o_clk_en=1; counter wraps 7→0 every 8 cycles.
- In RUN at ratio 8, send ratio 5 at cnt=2:
  - o_busy=1 and o_cfg_ready=0 until the boundary at cnt=7.
  - o_div_ratio=5 on the next cycle; a second request sent while busy is ignored.
- Send ratio 0 and ratio 1 → o_cfg_err pulses 1 cycle each; o_div_ratio unchanged.
- In RUN at ratio 7, drop i_enable at cnt=3 → o_clk_en stays 1 through cnt=6, then 0; state IDLE.
- Assert i_rst_n=0 while PEND (ratio 9 pending) → next cycle o_div_ratio=2, o_busy=0, o_clk_en=0; the pending value is discarded.
